// File: rtl/sram_blwl_programmer.sv
//============================================================================
// Module      : sram_blwl_programmer
// Description : Write-side driver for a NUM_WL x NUM_BL bl/wl-programmed
//               SRAM configuration array. Assembles each row from a serial
//               valid/ready bitstream (bit 0 first), drives it onto bl, then
//               pulses the selected wl with bl held one cycle before and
//               one cycle after the pulse.
//               Optional macro SRAM_BLWL_PARITY_EN: each row carries one
//               extra even-parity bit; a mismatch sets the sticky err flag,
//               skips the row write and ends programming.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_blwl_programmer #(
    parameter int NUM_BL   = 8,
    parameter int NUM_WL   = 4,
    parameter int WL_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef SRAM_BLWL_PARITY_EN
    localparam int c_EXTRA = 1;
`else
    localparam int c_EXTRA = 0;
`endif

    localparam int c_BC_W  = ($clog2(NUM_BL + 1) < 1) ? 1 : $clog2(NUM_BL + 1);
    localparam int c_ROW_W = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
    localparam int c_PC_W  = ($clog2(WL_PULSE + 1) < 1) ? 1 : $clog2(WL_PULSE + 1);

    // Index of the last serial bit of a row (the parity bit when enabled)
    localparam logic [c_BC_W-1:0]  c_LAST_BIT  = c_BC_W'(NUM_BL - 1 + c_EXTRA);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW  = c_ROW_W'(NUM_WL - 1);
    localparam logic [c_PC_W-1:0]  c_PULSE_MAX = c_PC_W'(WL_PULSE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    logic [c_BC_W-1:0]   r_bitcnt;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_PC_W-1:0]   r_pcnt;
    logic [NUM_BL-1:0]   r_sr;
    logic [NUM_BL-1:0]   r_bl;
    logic [NUM_WL-1:0]   r_wl;
    logic                r_busy;
    logic                r_done;
    logic [NUM_BL-1:0]   w_sr_next;
    logic [NUM_WL-1:0]   w_wl_sel;

    // Shift register with the current serial bit merged at position bitcnt;
    // the parity position (bitcnt == NUM_BL) matches no data bit.
    always_comb begin
        w_sr_next = r_sr;
        for (int i = 0; i < NUM_BL; i++) begin
            if (r_bitcnt == c_BC_W'(i)) begin
                w_sr_next[i] = din;
            end
        end
    end

    // One-hot decode of the current row for the word-line bus
    always_comb begin
        w_wl_sel = '0;
        for (int i = 0; i < NUM_WL; i++) begin
            w_wl_sel[i] = (r_row == c_ROW_W'(i));
        end
    end

`ifdef SRAM_BLWL_PARITY_EN
    logic r_err;
    logic w_par_ok;

    // Even parity over the NUM_BL data bits plus the incoming parity bit
    assign w_par_ok = ~(^r_sr ^ din);
    assign err      = r_err;

    // Sticky parity error: cleared by reset or an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_err <= 1'b0;
        end else if (r_state == S_LOAD && din_valid && r_bitcnt == c_LAST_BIT && !w_par_ok) begin
            r_err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign din_ready = (r_state == S_LOAD);
    assign bl        = r_bl;
    assign wl        = r_wl;
    assign busy      = r_busy;
    assign done      = r_done;

    // Main sequencer: load row, bl setup, wl pulse, bl hold, next row / done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_row    <= '0;
            r_pcnt   <= '0;
            r_sr     <= '0;
            r_bl     <= '0;
            r_wl     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_bl <= '0;
                    r_wl <= '0;
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_row    <= '0;
                        r_bitcnt <= '0;
                        r_sr     <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (din_valid) begin
                        r_sr <= w_sr_next;
                        if (r_bitcnt == c_LAST_BIT) begin
                            r_bitcnt <= '0;
`ifdef SRAM_BLWL_PARITY_EN
                            if (!w_par_ok) begin
                                // Corrupt row is never written; finish immediately
                                r_bl    <= '0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_bl    <= w_sr_next;
                                r_state <= S_SETUP;
                            end
`else
                            r_bl    <= w_sr_next;
                            r_state <= S_SETUP;
`endif
                        end else begin
                            r_bitcnt <= r_bitcnt + c_BC_W'(1);
                        end
                    end
                end
                S_SETUP: begin
                    r_wl    <= w_wl_sel;
                    r_pcnt  <= c_PC_W'(1);
                    r_state <= S_PULSE;
                end
                S_PULSE: begin
                    if (r_pcnt == c_PULSE_MAX) begin
                        r_wl    <= '0;
                        r_state <= S_HOLD;
                    end else begin
                        r_pcnt <= r_pcnt + c_PC_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_row == c_LAST_ROW) begin
                        r_bl    <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_row   <= r_row + c_ROW_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wl    <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_blwl_programmer.sv
//============================================================================
// Module      : tb_sram_blwl_programmer
// Description : Self-checking bench for sram_blwl_programmer. Records a
//               per-cycle trace of the outputs, extracts wl pulses and
//               compares them with the row values and cycle timing that
//               follow from the block's programming rules.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_blwl_programmer;

    localparam int NB   = 8;
    localparam int NW   = 4;
    localparam int WP   = 2;
`ifdef SRAM_BLWL_PARITY_EN
    localparam int E    = 1;
`else
    localparam int E    = 0;
`endif
    localparam int C    = NB + 2 + WP + E;   // cycles per row, continuous valid
    localparam int MAXC = 300;

    logic clk = 1'b0;
    logic rst, start, din, din_valid;
    logic din_ready, busy, done, err;
    logic [NB-1:0] bl;
    logic [NW-1:0] wl;

    logic start2, din2, dv2;
    logic ready2, busy2, done2, err2;
    logic [0:0] bl2, wl2;

    int errors = 0;
    int checks = 0;

    logic [NB-1:0] g_rows [NW];
    bit            g_flip;

    logic [NB-1:0] t_bl    [MAXC];
    logic [NW-1:0] t_wl    [MAXC];
    logic          t_done  [MAXC];
    logic          t_busy  [MAXC];
    logic          t_ready [MAXC];
    logic          t_err   [MAXC];
    int            n_done, done_cyc, last_cyc;

    int            n_pulse;
    logic [NW-1:0] p_wl     [16];
    logic [NB-1:0] p_bl     [16];
    int            p_len    [16];
    int            p_start  [16];
    bit            p_stable [16];

    always #5 clk = ~clk;

    sram_blwl_programmer #(.NUM_BL(NB), .NUM_WL(NW), .WL_PULSE(WP)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .bl(bl), .wl(wl), .busy(busy), .done(done), .err(err)
    );

    sram_blwl_programmer #(.NUM_BL(1), .NUM_WL(1), .WL_PULSE(1)) dut_min (
        .clk(clk), .rst(rst), .start(start2), .din(din2), .din_valid(dv2),
        .din_ready(ready2), .bl(bl2), .wl(wl2), .busy(busy2), .done(done2), .err(err2)
    );

    // Program the whole array from g_rows. mode 0: continuous valid,
    // 1: valid on odd cycles during row 0, 2: random valid.
    // s1..s3: cycles where start is re-asserted; rc: cycle with rst high.
    task automatic run_prog(input int mode, input int s1, input int s2, input int s3,
                            input int rc, input int maxc);
        bit q[$];
        int acc;
        bit v;
        for (int r = 0; r < NW; r++) begin
            for (int b = 0; b < NB; b++) q.push_back(g_rows[r][b]);
            if (E == 1) q.push_back((^g_rows[r]) ^ (r == 0 && g_flip));
        end
        for (int c = 0; c < MAXC; c++) begin
            t_bl[c] = '0; t_wl[c] = '0; t_done[c] = 0; t_busy[c] = 0; t_ready[c] = 0; t_err[c] = 0;
        end
        n_done = 0; done_cyc = -1; last_cyc = 0; acc = 0;
        start = 1'b1; din_valid = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= maxc; c++) begin
            start = (c == s1 || c == s2 || c == s3);
            rst   = (c == rc);
            case (mode)
                0:       v = q.size() > 0;
                1:       v = (acc < NB + E) ? (c % 2 == 1) : (q.size() > 0);
                default: v = (q.size() > 0) && ($urandom_range(0, 1) != 0);
            endcase
            din_valid = v;
            din = (q.size() > 0) ? q[0] : 1'b0;
            @(negedge clk);
            t_bl[c] = bl; t_wl[c] = wl; t_done[c] = done; t_busy[c] = busy;
            t_ready[c] = din_ready; t_err[c] = err;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (din_ready && din_valid && q.size() > 0) begin
                void'(q.pop_front());
                acc++;
            end
            last_cyc = c;
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; rst = 1'b0; din_valid = 1'b0;
        // Extract word-line pulses from the trace
        n_pulse = 0;
        for (int c = 1; c <= last_cyc; c++) begin
            if (t_wl[c] != '0 && t_wl[c-1] == '0) begin
                int e;
                e = c;
                while (e < last_cyc && t_wl[e+1] != '0) e++;
                if (n_pulse < 16) begin
                    p_wl[n_pulse] = t_wl[c]; p_bl[n_pulse] = t_bl[c];
                    p_len[n_pulse] = e - c + 1; p_start[n_pulse] = c; p_stable[n_pulse] = 1;
                    for (int k = c - 1; k <= e + 1 && k <= last_cyc; k++)
                        if (t_bl[k] !== t_bl[c]) p_stable[n_pulse] = 0;
                    for (int k = c; k <= e; k++)
                        if (t_wl[k] !== t_wl[c]) p_stable[n_pulse] = 0;
                end
                n_pulse++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; din = 1'b1; din_valid = 1'b1;
        start2 = 1'b1; din2 = 1'b1; dv2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (bl !== '0)       begin errors++; $display("FAIL reset_bl: got %0h expected 0", bl); end
        checks++; if (wl !== '0)       begin errors++; $display("FAIL reset_wl: got %0h expected 0", wl); end
        checks++; if (din_ready !== 0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", din_ready); end
        checks++; if (busy !== 0)      begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 0)      begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (err !== 0)       begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (busy2 !== 0 || wl2 !== 0) begin errors++; $display("FAIL reset_min: got busy=%0b wl=%0b expected 0", busy2, wl2); end
        rst = 1'b0; start = 1'b0; din_valid = 1'b0; start2 = 1'b0; dv2 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_program;
        logic [NW-1:0] exp_wl;
        bit any_err;
        g_rows[0] = NB'(8'hA5); g_rows[1] = NB'(8'h3C); g_rows[2] = NB'(8'hFF); g_rows[3] = NB'(8'h00);
        g_flip = 0;
        run_prog(0, -1, -1, -1, -1, MAXC - 3);
        checks++; if (n_pulse != NW) begin errors++; $display("FAIL prog_npulse: got %0d expected %0d", n_pulse, NW); end
        for (int p = 0; p < NW && p < n_pulse; p++) begin
            exp_wl = '0; exp_wl[p] = 1'b1;
            checks++; if (p_wl[p] !== exp_wl)   begin errors++; $display("FAIL prog_wl row%0d: got %0h expected %0h", p, p_wl[p], exp_wl); end
            checks++; if (p_bl[p] !== g_rows[p]) begin errors++; $display("FAIL prog_bl row%0d: got %0h expected %0h", p, p_bl[p], g_rows[p]); end
            checks++; if (p_len[p] != WP)       begin errors++; $display("FAIL prog_len row%0d: got %0d expected %0d", p, p_len[p], WP); end
            checks++; if (!p_stable[p])         begin errors++; $display("FAIL prog_bl_stable row%0d: got 0 expected 1", p); end
            checks++; if (p_start[p] != 1 + p*C + NB + E + 1) begin errors++; $display("FAIL prog_pulse_cycle row%0d: got %0d expected %0d", p, p_start[p], 1 + p*C + NB + E + 1); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL prog_ndone: got %0d expected 1", n_done); end
        checks++; if (done_cyc != 1 + NW*C) begin errors++; $display("FAIL prog_done_cycle: got %0d expected %0d", done_cyc, 1 + NW*C); end
        if (done_cyc > 0) begin
            checks++; if (t_busy[done_cyc] !== 1'b1)   begin errors++; $display("FAIL prog_busy_at_done: got %0b expected 1", t_busy[done_cyc]); end
            checks++; if (t_busy[done_cyc+1] !== 1'b0) begin errors++; $display("FAIL prog_busy_after_done: got %0b expected 0", t_busy[done_cyc+1]); end
            checks++; if (t_bl[done_cyc+1] !== '0)     begin errors++; $display("FAIL prog_bl_idle: got %0h expected 0", t_bl[done_cyc+1]); end
        end
        any_err = 0;
        for (int c = 1; c <= last_cyc; c++) if (t_err[c] !== 1'b0) any_err = 1;
        checks++; if (any_err) begin errors++; $display("FAIL prog_err: got 1 expected 0"); end
    endtask

    task automatic test_stall;
        bit all_ready;
        g_rows[0] = NB'(8'h81);
        for (int r = 1; r < NW; r++) g_rows[r] = NB'($urandom);
        g_flip = 0;
        run_prog(1, -1, -1, -1, -1, MAXC - 3);
        all_ready = 1;
        for (int c = 1; c <= 2*(NB+E) - 1; c++) if (t_ready[c] !== 1'b1) all_ready = 0;
        checks++; if (!all_ready) begin errors++; $display("FAIL stall_ready: got 0 expected 1"); end
        checks++; if (n_pulse != NW) begin errors++; $display("FAIL stall_npulse: got %0d expected %0d", n_pulse, NW); end
        if (n_pulse > 0) begin
            checks++; if (p_start[0] != 2*(NB+E) + 1) begin errors++; $display("FAIL stall_first_pulse: got %0d expected %0d", p_start[0], 2*(NB+E) + 1); end
            checks++; if (p_bl[0] !== g_rows[0])     begin errors++; $display("FAIL stall_bl: got %0h expected %0h", p_bl[0], g_rows[0]); end
            checks++; if (p_wl[0] !== NW'(1))        begin errors++; $display("FAIL stall_wl: got %0h expected 1", p_wl[0]); end
        end
        checks++; if (done_cyc != 1 + NW*C + NB + E - 1) begin errors++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_cyc, 1 + NW*C + NB + E - 1); end
    endtask

    task automatic test_start_ignored;
        logic [NW-1:0] exp_wl;
        for (int r = 0; r < NW; r++) g_rows[r] = NB'($urandom);
        g_flip = 0;
        run_prog(0, 3, NB + E + 2, 1 + NW*C, -1, MAXC - 3);
        checks++; if (n_pulse != NW) begin errors++; $display("FAIL restart_npulse: got %0d expected %0d", n_pulse, NW); end
        for (int p = 0; p < NW && p < n_pulse; p++) begin
            exp_wl = '0; exp_wl[p] = 1'b1;
            checks++; if (p_wl[p] !== exp_wl || p_bl[p] !== g_rows[p] || p_len[p] != WP)
                begin errors++; $display("FAIL restart_row%0d: got wl=%0h bl=%0h len=%0d expected wl=%0h bl=%0h len=%0d", p, p_wl[p], p_bl[p], p_len[p], exp_wl, g_rows[p], WP); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL restart_ndone: got %0d expected 1", n_done); end
        checks++; if (done_cyc != 1 + NW*C) begin errors++; $display("FAIL restart_done_cycle: got %0d expected %0d", done_cyc, 1 + NW*C); end
        if (done_cyc > 0) begin
            checks++; if (t_busy[done_cyc+1] !== 1'b0 || t_ready[done_cyc+1] !== 1'b0)
                begin errors++; $display("FAIL restart_in_done: got busy=%0b ready=%0b expected 0 0", t_busy[done_cyc+1], t_ready[done_cyc+1]); end
        end
    endtask

    task automatic test_reset_mid;
        int rc;
        logic [NW-1:0] exp_wl;
        rc = 1 + 2*C + NB + E + 1;
        for (int r = 0; r < NW; r++) g_rows[r] = NB'($urandom);
        g_flip = 0;
        run_prog(0, -1, -1, -1, rc, rc + 1);
        exp_wl = '0; exp_wl[2] = 1'b1;
        checks++; if (t_wl[rc] !== exp_wl) begin errors++; $display("FAIL rstmid_in_pulse: got %0h expected %0h", t_wl[rc], exp_wl); end
        checks++; if (t_wl[rc+1] !== '0 || t_bl[rc+1] !== '0)
            begin errors++; $display("FAIL rstmid_outputs: got wl=%0h bl=%0h expected 0 0", t_wl[rc+1], t_bl[rc+1]); end
        checks++; if (t_busy[rc+1] !== 1'b0 || t_ready[rc+1] !== 1'b0)
            begin errors++; $display("FAIL rstmid_idle: got busy=%0b ready=%0b expected 0 0", t_busy[rc+1], t_ready[rc+1]); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL rstmid_ndone: got %0d expected 0", n_done); end
        for (int r = 0; r < NW; r++) g_rows[r] = NB'($urandom);
        run_prog(0, -1, -1, -1, -1, MAXC - 3);
        checks++; if (n_pulse != NW) begin errors++; $display("FAIL rstmid_re_npulse: got %0d expected %0d", n_pulse, NW); end
        for (int p = 0; p < NW && p < n_pulse; p++) begin
            exp_wl = '0; exp_wl[p] = 1'b1;
            checks++; if (p_wl[p] !== exp_wl || p_bl[p] !== g_rows[p])
                begin errors++; $display("FAIL rstmid_re_row%0d: got wl=%0h bl=%0h expected wl=%0h bl=%0h", p, p_wl[p], p_bl[p], exp_wl, g_rows[p]); end
        end
        checks++; if (done_cyc != 1 + NW*C) begin errors++; $display("FAIL rstmid_re_done: got %0d expected %0d", done_cyc, 1 + NW*C); end
    endtask

    task automatic test_random;
        logic [NW-1:0] exp_wl;
        for (int it = 0; it < 3; it++) begin
            for (int r = 0; r < NW; r++) g_rows[r] = NB'($urandom);
            g_flip = 0;
            run_prog(2, -1, -1, -1, -1, MAXC - 3);
            checks++; if (n_pulse != NW) begin errors++; $display("FAIL rand%0d_npulse: got %0d expected %0d", it, n_pulse, NW); end
            for (int p = 0; p < NW && p < n_pulse; p++) begin
                exp_wl = '0; exp_wl[p] = 1'b1;
                checks++; if (p_wl[p] !== exp_wl || p_bl[p] !== g_rows[p] || p_len[p] != WP || !p_stable[p])
                    begin errors++; $display("FAIL rand%0d_row%0d: got wl=%0h bl=%0h len=%0d stable=%0b expected wl=%0h bl=%0h len=%0d stable=1", it, p, p_wl[p], p_bl[p], p_len[p], p_stable[p], exp_wl, g_rows[p], WP); end
            end
            checks++; if (n_done != 1) begin errors++; $display("FAIL rand%0d_ndone: got %0d expected 1", it, n_done); end
        end
    endtask

    task automatic test_min_config;
        bit q2[$];
        bit b;
        int wl_cnt, wl_first, dc;
        logic m_bl [16];
        b = ($urandom_range(0, 1) != 0);
        q2.push_back(b);
        if (E == 1) q2.push_back(b);
        for (int c = 0; c < 16; c++) m_bl[c] = 1'b0;
        wl_cnt = 0; wl_first = -1; dc = -1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            dv2  = q2.size() > 0;
            din2 = (q2.size() > 0) ? q2[0] : 1'b0;
            @(negedge clk);
            m_bl[c] = bl2[0];
            if (wl2[0] === 1'b1) begin
                wl_cnt++;
                if (wl_first < 0) wl_first = c;
            end
            if (done2 === 1'b1 && dc < 0) dc = c;
            if (ready2 && dv2 && q2.size() > 0) void'(q2.pop_front());
            @(posedge clk); #1;
        end
        dv2 = 1'b0;
        checks++; if (wl_cnt != 1)       begin errors++; $display("FAIL min_wl_cycles: got %0d expected 1", wl_cnt); end
        checks++; if (wl_first != 3 + E) begin errors++; $display("FAIL min_wl_cycle: got %0d expected %0d", wl_first, 3 + E); end
        if (wl_first > 1 && wl_first < 15) begin
            checks++; if (m_bl[wl_first-1] !== b || m_bl[wl_first] !== b || m_bl[wl_first+1] !== b)
                begin errors++; $display("FAIL min_bl: got %0b%0b%0b expected %0b", m_bl[wl_first-1], m_bl[wl_first], m_bl[wl_first+1], b); end
        end
        checks++; if (dc != 5 + E) begin errors++; $display("FAIL min_done_cycle: got %0d expected %0d", dc, 5 + E); end
    endtask

`ifdef SRAM_BLWL_PARITY_EN
    task automatic test_parity;
        g_rows[0] = NB'(1);
        for (int r = 1; r < NW; r++) g_rows[r] = NB'($urandom);
        g_flip = 1;
        run_prog(0, -1, -1, -1, -1, MAXC - 3);
        checks++; if (n_pulse != 0) begin errors++; $display("FAIL par_bad_npulse: got %0d expected 0", n_pulse); end
        checks++; if (n_done != 1)  begin errors++; $display("FAIL par_bad_ndone: got %0d expected 1", n_done); end
        checks++; if (done_cyc != NB + 2) begin errors++; $display("FAIL par_bad_done_cycle: got %0d expected %0d", done_cyc, NB + 2); end
        checks++; if (t_err[last_cyc] !== 1'b1) begin errors++; $display("FAIL par_bad_err: got %0b expected 1", t_err[last_cyc]); end
        g_flip = 0;
        run_prog(0, -1, -1, -1, -1, MAXC - 3);
        checks++; if (t_err[1] !== 1'b0) begin errors++; $display("FAIL par_err_clear: got %0b expected 0", t_err[1]); end
        checks++; if (n_pulse != NW) begin errors++; $display("FAIL par_good_npulse: got %0d expected %0d", n_pulse, NW); end
        if (n_pulse > 0) begin
            checks++; if (p_bl[0] !== NB'(1) || p_wl[0] !== NW'(1))
                begin errors++; $display("FAIL par_good_row0: got wl=%0h bl=%0h expected wl=1 bl=1", p_wl[0], p_bl[0]); end
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL par_good_ndone: got %0d expected 1", n_done); end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0;
        start2 = 1'b0; din2 = 1'b0; dv2 = 1'b0; g_flip = 0;
        test_reset();
        test_program();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_min_config();
`ifdef SRAM_BLWL_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
